serial_full_add: RTL

SERIAL_FULL_ADD -- requirements
Module: serial_full_add

---
 rtl/serial_full_add_if.sv | 28 ++
 rtl/serial_full_add.sv | 94 +++++++++
 2 files changed

// File: rtl/serial_full_add_if.sv
// Operand/result bundle for the bit-serial adder. The master starts operations
// and the slave reports progress and results.
interface serial_full_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state;

  // Handshake: start is a level request that counts only while the slave is
  // idle (busy=0, done=0). The accepting edge captures a/b/cin. done is a
  // one-cycle pulse, and sum/cout are valid from that pulse until the next one.
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, state
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, state
  );
endinterface

// File: rtl/serial_full_add.sv
// Bit-serial unsigned adder. One full-add cell runs LSB first for WIDTH cycles,
// and the result registers are updated only at the completion edge.
module serial_full_add #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_full_add_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_c, last_bit;
  logic             accept, busy_c, done_c;

  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The result shifts in at the MSB, so the LSB-first stream lands in order
  // after WIDTH steps. The last bit is merged directly into sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
      res_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= bit_c;
      res_sr <= {bit_s, res_sr[WIDTH-1:1]};
      if (last_bit) begin
        sum_q  <= {bit_s, res_sr[WIDTH-1:1]};
        cout_q <= bit_c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.state = state;
endmodule
